// File: rtl/text_cursor_writer.sv
// text_cursor_writer
//   Feeds the text-buffer VGA display. Accepts ASCII bytes over a valid/ready
//   handshake, keeps a cursor, and emits one character-cell write per cycle.
//   Handles line wrap, CR, LF, backspace and form feed; blanks the new row on
//   every line advance and the whole screen on reset or form feed.
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   in_data/in_valid  ASCII byte and its valid strobe
//   in_ready          byte can be accepted this cycle (IDLE only)
//   write_enable      single-cell write strobe into the character buffer
//   write_x/y/data    cell column, row and 7-bit character code
//   cursor_x/y        current cursor position
//   busy              a row or screen clear is in progress
module text_cursor_writer #(
    parameter int unsigned COLS  = 80,
    parameter int unsigned ROWS  = 30,
    parameter logic [6:0]  BLANK = 7'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       write_enable,
    output logic [6:0] write_x,
    output logic [4:0] write_y,
    output logic [6:0] write_data,
    output logic [6:0] cursor_x,
    output logic [4:0] cursor_y,
    output logic       busy
);

    localparam int unsigned XW = 7;
    localparam int unsigned YW = 5;
    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        CLEAR_ROW = 2'd1,
        IDLE      = 2'd2
    } state_t;

    state_t        state;
    logic [XW-1:0] clr_x;
    logic [YW-1:0] clr_y;
    logic [YW-1:0] y_next;
    logic          accept;
    logic          printable;

    // Row below the cursor, wrapping to the top (no scrolling).
    assign y_next    = (cursor_y == Y_LAST) ? '0 : cursor_y + YW'(1);
    assign accept    = in_valid && in_ready;
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

    // Single-process FSM; every output is a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= CLEAR_ALL;
            clr_x        <= '0;
            clr_y        <= '0;
            cursor_x     <= '0;
            cursor_y     <= '0;
            write_enable <= 1'b0;
            write_x      <= '0;
            write_y      <= '0;
            write_data   <= '0;
            in_ready     <= 1'b0;
            busy         <= 1'b1;
        end else begin
            write_enable <= 1'b0;
            case (state)
                CLEAR_ALL: begin
                    write_enable <= 1'b1;
                    write_x      <= clr_x;
                    write_y      <= clr_y;
                    write_data   <= BLANK;
                    if (clr_x == X_LAST) begin
                        clr_x <= '0;
                        if (clr_y == Y_LAST) begin
                            clr_y    <= '0;
                            state    <= IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            clr_y <= clr_y + YW'(1);
                        end
                    end else begin
                        clr_x <= clr_x + XW'(1);
                    end
                end

                // Blanks the row the cursor has just moved onto.
                CLEAR_ROW: begin
                    write_enable <= 1'b1;
                    write_x      <= clr_x;
                    write_y      <= cursor_y;
                    write_data   <= BLANK;
                    if (clr_x == X_LAST) begin
                        clr_x    <= '0;
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        clr_x <= clr_x + XW'(1);
                    end
                end

                IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            write_enable <= 1'b1;
                            write_x      <= cursor_x;
                            write_y      <= cursor_y;
                            write_data   <= in_data[6:0];
                            if (cursor_x != X_LAST) begin
                                cursor_x <= cursor_x + XW'(1);
                            end else begin
                                cursor_x <= '0;
                                cursor_y <= y_next;
                                clr_x    <= '0;
                                state    <= CLEAR_ROW;
                                in_ready <= 1'b0;
                                busy     <= 1'b1;
                            end
                        end else begin
                            case (in_data)
                                8'h0D: cursor_x <= '0;
                                8'h0A: begin
                                    cursor_x <= '0;
                                    cursor_y <= y_next;
                                    clr_x    <= '0;
                                    state    <= CLEAR_ROW;
                                    in_ready <= 1'b0;
                                    busy     <= 1'b1;
                                end
                                8'h08: begin
                                    // Backspace blanks the cell it steps back onto.
                                    if (cursor_x != '0) begin
                                        cursor_x     <= cursor_x - XW'(1);
                                        write_enable <= 1'b1;
                                        write_x      <= cursor_x - XW'(1);
                                        write_y      <= cursor_y;
                                        write_data   <= BLANK;
                                    end
                                end
                                8'h0C: begin
                                    cursor_x <= '0;
                                    cursor_y <= '0;
                                    clr_x    <= '0;
                                    clr_y    <= '0;
                                    state    <= CLEAR_ALL;
                                    in_ready <= 1'b0;
                                    busy     <= 1'b1;
                                end
                                default: ;  // other bytes are consumed and dropped
                            endcase
                        end
                    end
                end

                default: begin
                    state    <= CLEAR_ALL;
                    clr_x    <= '0;
                    clr_y    <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_cursor_writer.sv
// Testbench for text_cursor_writer: directed scenarios plus random bytes.
// The stimulus side runs a cursor model and queues every cell write it
// expects; an independent monitor pops the queue on each write strobe.
module tb_text_cursor_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int BLANK = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       write_enable;
    logic [6:0] write_x;
    logic [4:0] write_y;
    logic [6:0] write_data;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;
    logic       busy;

    text_cursor_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(7'h20)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .write_enable(write_enable), .write_x(write_x),
        .write_y(write_y), .write_data(write_data), .cursor_x(cursor_x),
        .cursor_y(cursor_y), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  mx = 0;
    int  my = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_wr(input int x, input int y, input int d);
        wr_t w;
        w.x = x; w.y = y; w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic push_row(input int y);
        for (int c = 0; c < COLS; c++) push_wr(c, y, BLANK);
    endtask

    task automatic push_screen();
        for (int r = 0; r < ROWS; r++) push_row(r);
    endtask

    // Reference behaviour of one accepted byte.
    task automatic model_byte(input int b);
        if (b >= 32 && b <= 126) begin
            push_wr(mx, my, b);
            if (mx < COLS - 1) mx++;
            else begin
                mx = 0;
                my = (my + 1) % ROWS;
                push_row(my);
            end
        end else if (b == 13) begin
            mx = 0;
        end else if (b == 10) begin
            mx = 0;
            my = (my + 1) % ROWS;
            push_row(my);
        end else if (b == 8) begin
            if (mx > 0) begin
                mx--;
                push_wr(mx, my, BLANK);
            end
        end else if (b == 12) begin
            mx = 0;
            my = 0;
            push_screen();
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) chk("in_ready_while_busy", int'(in_ready), 0);
            if (write_enable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=(%0d,%0d)=%0d required=none",
                             write_x, write_y, write_data);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("write_x", int'(write_x), w.x);
                    chk("write_y", int'(write_y), w.y);
                    chk("write_data", int'(write_data), w.d);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int b);
        int n;
        n = 0;
        in_data  = 8'(b);
        in_valid = 1'b1;
        while (!in_ready && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        model_byte(b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("cursor_x", int'(cursor_x), mx);
        chk("cursor_y", int'(cursor_y), my);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        chk("drain_in_ready", int'(in_ready), 1);
    endtask

    task automatic check_reset_values();
        chk("rst_write_enable", int'(write_enable), 0);
        chk("rst_write_x", int'(write_x), 0);
        chk("rst_write_y", int'(write_y), 0);
        chk("rst_write_data", int'(write_data), 0);
        chk("rst_cursor_x", int'(cursor_x), 0);
        chk("rst_cursor_y", int'(cursor_y), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 1);
    endtask

    task automatic random_byte(output int b);
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 70)      b = int'($urandom_range(32, 126));
        else if (r < 77) b = 13;
        else if (r < 85) b = 10;
        else if (r < 93) b = 8;
        else if (r < 95) b = 12;
        else begin
            case ($urandom_range(0, 3))
                0: b = 0;
                1: b = 7;
                2: b = 127;
                default: b = int'($urandom_range(128, 255));
            endcase
        end
    endtask

    string msg;

    initial begin
        int b;
        // Reset and the power-up clear.
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        push_screen();
        reset = 1'b0;
        drain();
        chk("init_cursor_x", int'(cursor_x), 0);
        chk("init_cursor_y", int'(cursor_y), 0);
        chk("init_busy", int'(busy), 0);

        // Back-to-back printable bytes.
        msg = "I AM";
        for (int i = 0; i < msg.len(); i++) send(int'(msg[i]));
        drain();

        // Full line of 'A' from column 0 wraps and blanks row 1.
        send(13);
        for (int i = 0; i < COLS; i++) send(65);
        drain();
        chk("wrap_cursor_y", int'(cursor_y), 1);

        // Backspace mid-row and at column 0.
        for (int i = 0; i < 4; i++) send(10);
        send(97); send(98); send(99);
        send(8);
        send(8); send(8);
        send(8);
        drain();

        // LF from the last row wraps to row 0; CR and BEL write nothing.
        while (my != ROWS - 1) send(10);
        for (int i = 0; i < 10; i++) send(120);
        send(10);
        drain();
        send(65); send(66);
        send(13);
        send(7);
        drain();

        // Random traffic with idle gaps.
        for (int i = 0; i < 300; i++) begin
            random_byte(b);
            send(b);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        drain();

        // Reset in the middle of a row clear restarts the full clear.
        send(10);
        repeat (40) @(posedge clk);
        #1;
        chk("mid_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check_reset_values();
        @(posedge clk); #1;
        exp_q.delete();
        mx = 0;
        my = 0;
        push_screen();
        reset = 1'b0;
        drain();
        chk("restart_cursor_x", int'(cursor_x), 0);
        chk("restart_cursor_y", int'(cursor_y), 0);
        send(90);
        drain();

        // Quiet period: no stray writes may appear.
        repeat (20) @(posedge clk);
        #1;
        chk("final_pending", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
